score_collector: RTL and testbench
==================================

# score_collector

Upstream feeder for `top_sort_display`. It accepts the ten signed class scores produced serially by the final PE/FC layer over a valid/ready stream and packs them into the 160-bit `data` bus the sorter consumes. It pulses `load` for a fixed number of cycles, then waits for the sorter's `complete` before releasing the next frame. It can pre-collect most of the next frame while the sorter is busy.

## Interface
- `N_CLASS`, default 10: scores per frame.
- `SCORE_W`, default 16: signed score width.
- `LOAD_CYCLES`, default 2: number of cycles `load` is held high per frame.
- `TIMEOUT`, default 1024: number of WAIT cycles without a `complete` rising edge before abort.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  score beat valid.
- `in_ready`  out  1  beat accepted when `in_valid & in_ready`.
- `in_data`  in  SCORE_W  signed score.
- `in_last`  in  1  marks the final beat of a frame.
- `data_out`  out  N_CLASS*SCORE_W  packed scores; connects to sorter `data`.
- `load`  out  1  sorter load strobe.
- `complete`  in  1  sorter done level.
- `err_len`  out  1  one-cycle pulse on frame length error.
- `err_timeout`  out  1  one-cycle pulse on sorter timeout.
- `frame_cnt`  out  8  frames handed to the sorter; wraps 255→0.

## Operation
- Packing: the k-th accepted beat (k = 0 first) is class k and occupies bits [SCORE_W*k+SCORE_W-1 : SCORE_W*k]. Class 0 is at the LSB. Raw two's-complement bits are stored with no sign manipulation.
- Storage:
  - collect buffer `buf` plus beat counter `cnt` (0..N_CLASS-1).
  - separate output register `data_out`, stable from load until the next frame is transferred.
- States:
  - **COLLECT**
    - `in_ready`=1.
    - Each accepted beat writes `buf[cnt]`.
    - Accepted beat with `cnt`==N_CLASS-1 and `in_last`=1: copy `buf` with the new beat into `data_out`, increment `frame_cnt`, clear `cnt`, go to LOAD.
  - **LOAD**
    - `load`=1 for exactly LOAD_CYCLES cycles, then go to WAIT.
    - `in_ready`=0.
    - `complete` edges are ignored, but the `complete` history register keeps updating.
  - **WAIT**
    - `in_ready`=1 only while `cnt` < N_CLASS-1. The final beat of the next frame stalls.
    - A `complete` rising edge (`complete` & ~`complete_d`) moves to COLLECT on the next cycle.
    - After TIMEOUT cycles in WAIT with no edge: pulse `err_timeout`, go to COLLECT. The partial buffer and `cnt` are preserved.
- Length errors, in COLLECT or WAIT:
  - `in_last`=1 on an accepted beat with `cnt` < N_CLASS-1 → pulse `err_len`, discard the frame (`cnt`=0).
  - Accepted beat with `cnt`==N_CLASS-1 and `in_last`=0 → pulse `err_len`, discard (`cnt`=0).
  - Errored frames never assert `load` and do not change `data_out` or `frame_cnt`.
- Reset:
  - `state`=COLLECT, `cnt`=0, `buf`=0, `data_out`=0, `load`=0, `err_*`=0, `frame_cnt`=0, `complete_d`=0.
  - `in_ready`=0 while `rst` is high.
  - Reset mid-LOAD or mid-WAIT aborts immediately. The sorter result is not awaited.

## Timing
- Last beat accepted at cycle t → `data_out` valid and `load`=1 in cycles t+1 .. t+LOAD_CYCLES.
- `complete` rising edge sampled at cycle u in WAIT → state=COLLECT at u+1.
  - A stalled last beat can be accepted at u+1 at the earliest.
  - Its `load` then starts at u+2.
- A `complete` edge in the same cycle as the TIMEOUT expiry counts as the edge: no `err_timeout`.
- The WAIT cycle counter clears on entry to WAIT.
- `err_len`/`err_timeout` are registered and assert the cycle after the causing event.
- `frame_cnt` updates in the same cycle `data_out` updates.

## Structure
- Shared package `ddnet_sort_pkg`: `N_CLASS`, `SCORE_W`, the score type (signed [SCORE_W-1:0]), and the state encoding {COLLECT, LOAD, WAIT}. The sorter and its top reuse the same constants.
- No sub-module needed. The edge detector and the LOAD/timeout counters are inline.

## Test plan
- Reset: hold `rst` 3 cycles → all outputs 0, `in_ready`=0. After release, `in_ready`=1.
- Nominal frame:
  - Stimulus: beats 4,1,2,3,9,5,0,7,8,6 with `in_last` on the 10th.
  - Required: `data_out`=160'h0006_0008_0007_0000_0005_0009_0003_0002_0001_0004.
  - `load` high exactly 2 cycles starting the cycle after the last beat; `frame_cnt`=1.
- Short frame: `in_last` on the 6th beat → `err_len` pulses once, no `load`, `data_out` unchanged. The following 10-beat frame loads normally.
- Overlap: during WAIT send the 10 beats of frame 2 → beats 0–8 accepted, beat 9 stalls with `in_ready`=0. Raise `complete` → beat 9 accepted one cycle after the edge; `load` for frame 2 follows.
- Timeout: with TIMEOUT=64, hold `complete`=0 after `load` → `err_timeout` pulses after 64 WAIT cycles, state returns to COLLECT, `frame_cnt` unchanged.
- Negative scores and reset:
  - Frame of all -1 → `data_out` = 160'hFFFF…FFFF.
  - Assert `rst` mid-WAIT → `data_out`=0, `load`=0, state COLLECT.

Source files
------------

// File: rtl/ddnet_sort_pkg.sv
// Shared constants and types for the score collector and the downstream sorter.
package ddnet_sort_pkg;

  localparam int unsigned N_CLASS = 10;
  localparam int unsigned SCORE_W = 16;

  typedef logic signed [SCORE_W-1:0] score_t;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_LOAD    = 2'd1,
    ST_WAIT    = 2'd2
  } state_t;

endpackage

// File: rtl/score_collector.sv
// Collects N_CLASS serial scores into a packed bus, strobes the sorter load and
// holds off the next frame's final beat until the sorter signals completion.
module score_collector #(
  parameter int unsigned N_CLASS     = ddnet_sort_pkg::N_CLASS,
  parameter int unsigned SCORE_W     = ddnet_sort_pkg::SCORE_W,
  parameter int unsigned LOAD_CYCLES = 2,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SCORE_W-1:0]         in_data,
  input  logic                       in_last,
  output logic [N_CLASS*SCORE_W-1:0] data_out,
  output logic                       load,
  input  logic                       complete,
  output logic                       err_len,
  output logic                       err_timeout,
  output logic [7:0]                 frame_cnt
);

  import ddnet_sort_pkg::state_t;
  import ddnet_sort_pkg::ST_COLLECT;
  import ddnet_sort_pkg::ST_LOAD;
  import ddnet_sort_pkg::ST_WAIT;

  localparam int unsigned BUS_W = N_CLASS * SCORE_W;
  localparam int unsigned CNT_W = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;
  localparam int unsigned LD_W  = $clog2(LOAD_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_CLASS - 1);
  localparam logic [LD_W-1:0]  LD_LAST  = LD_W'(LOAD_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BUS_W-1:0]   buf_q, buf_d;
  logic [BUS_W-1:0]   data_q, data_d;
  logic [7:0]         frame_q, frame_d;
  logic [LD_W-1:0]    ld_cnt_q, ld_cnt_d;
  logic [TO_W-1:0]    wait_q, wait_d;
  logic               load_q, load_d;
  logic               in_ready_q, in_ready_d;
  logic               err_len_q, err_len_d;
  logic               err_to_q, err_to_d;
  logic               complete_d_q;
  logic               accept_c;
  logic               rise_c;

  assign accept_c = in_valid & in_ready_q;
  assign rise_c   = complete & ~complete_d_q;

  // Next-state: sequencing first, then beat handling which may start a LOAD.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    data_d    = data_q;
    frame_d   = frame_q;
    ld_cnt_d  = ld_cnt_q;
    wait_d    = wait_q;
    load_d    = 1'b0;
    err_len_d = 1'b0;
    err_to_d  = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (ld_cnt_q == LD_LAST) begin
          state_d = ST_WAIT;
          wait_d  = '0;
        end else begin
          ld_cnt_d = ld_cnt_q + LD_W'(1);
          load_d   = 1'b1;
        end
      end
      ST_WAIT: begin
        if (rise_c) begin
          state_d = ST_COLLECT;
        end else if (wait_q == TO_LAST) begin
          err_to_d = 1'b1;
          state_d  = ST_COLLECT;
        end else begin
          wait_d = wait_q + TO_W'(1);
        end
      end
      default: state_d = ST_COLLECT;
    endcase

    // The final beat can only be accepted in COLLECT because WAIT stalls it.
    if (accept_c) begin
      buf_d[int'(cnt_q)*SCORE_W +: SCORE_W] = in_data;
      if (cnt_q == LAST_IDX) begin
        cnt_d = '0;
        if (in_last) begin
          data_d   = buf_d;
          frame_d  = frame_q + 8'd1;
          state_d  = ST_LOAD;
          ld_cnt_d = '0;
          load_d   = 1'b1;
        end else begin
          err_len_d = 1'b1;
        end
      end else if (in_last) begin
        cnt_d     = '0;
        err_len_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    in_ready_d = (state_d == ST_COLLECT) ||
                 ((state_d == ST_WAIT) && (cnt_d < LAST_IDX));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_COLLECT;
      cnt_q        <= '0;
      buf_q        <= '0;
      data_q       <= '0;
      frame_q      <= '0;
      ld_cnt_q     <= '0;
      wait_q       <= '0;
      load_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      err_len_q    <= 1'b0;
      err_to_q     <= 1'b0;
      complete_d_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      buf_q        <= buf_d;
      data_q       <= data_d;
      frame_q      <= frame_d;
      ld_cnt_q     <= ld_cnt_d;
      wait_q       <= wait_d;
      load_q       <= load_d;
      in_ready_q   <= in_ready_d;
      err_len_q    <= err_len_d;
      err_to_q     <= err_to_d;
      complete_d_q <= complete;
    end
  end

  // Ready is forced low for the whole reset window, including its first cycle.
  assign in_ready    = in_ready_q & ~rst;
  assign data_out    = data_q;
  assign load        = load_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_to_q;
  assign frame_cnt   = frame_q;

endmodule

// File: tb/tb_score_collector.sv
// Self-checking bench for score_collector: vector table, hand-written corner
// sequences and random frames checked against a frame-level reference model.
module tb_score_collector;

  typedef logic [15:0] beats_t [10];

  typedef struct {
    beats_t       beats;
    int           nb;
    logic         lastf;
    logic         err;
    logic [159:0] exp_data;
    logic [7:0]   exp_fc;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [15:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic [159:0] data_out;
  logic         load;
  logic         complete = 1'b0;
  logic         err_len;
  logic         err_timeout;
  logic [7:0]   frame_cnt;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [159:0] m_data;
  logic [7:0]   m_fc;

  score_collector #(
    .N_CLASS(10), .SCORE_W(16), .LOAD_CYCLES(2), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .data_out(data_out), .load(load),
    .complete(complete), .err_len(err_len), .err_timeout(err_timeout),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] pack(input beats_t b);
    logic [159:0] r = '0;
    for (int k = 0; k < 10; k++) r[16*k +: 16] = b[k];
    return r;
  endfunction

  // Present one beat and hold it until the collector takes it.
  task automatic send_beat(input logic [15:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    if (!in_ready) begin
      checks++;
      fails++;
      $display("FAIL beat_accept_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input beats_t b, input int nb, input logic lastf, input int maxgap);
    for (int i = 0; i < nb; i++) begin
      repeat ($urandom_range(0, maxgap)) step();
      send_beat(b[i], (i == nb - 1) && lastf);
    end
  endtask

  // Called on the first load cycle: checks the load width, then pulses complete in WAIT.
  task automatic release_frame(input int maxdly);
    step();
    chk("load_cycle2", load, 1'b1);
    step();
    chk("load_ends", load, 1'b0);
    repeat ($urandom_range(0, maxdly)) step();
    complete = 1'b1;
    step();
    complete = 1'b0;
    step();
  endtask

  vec_t   tbl [5];
  beats_t fa, fb;
  int     c0, n, kind, nb;
  logic   lastf;

  initial begin
    // ---------------- reset ----------------
    #1;
    chk("rst_in_ready_first", in_ready, 1'b0);
    repeat (3) step();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_data_out", data_out, '0);
    chk("rst_load", load, 1'b0);
    chk("rst_err_len", err_len, 1'b0);
    chk("rst_err_timeout", err_timeout, 1'b0);
    chk("rst_frame_cnt", frame_cnt, 8'd0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", in_ready, 1'b1);

    // ---------------- vector table ----------------
    tbl[0].beats = '{16'd4, 16'd1, 16'd2, 16'd3, 16'd9, 16'd5, 16'd0, 16'd7, 16'd8, 16'd6};
    tbl[0].nb = 10; tbl[0].lastf = 1'b1; tbl[0].err = 1'b0; tbl[0].exp_fc = 8'd1;
    tbl[0].exp_data = 160'h0006_0008_0007_0000_0005_0009_0003_0002_0001_0004;

    tbl[1].beats = '{16'h11, 16'h22, 16'h33, 16'h44, 16'h55, 16'h66, 16'd0, 16'd0, 16'd0, 16'd0};
    tbl[1].nb = 6; tbl[1].lastf = 1'b1; tbl[1].err = 1'b1; tbl[1].exp_fc = 8'd1;
    tbl[1].exp_data = 160'h0006_0008_0007_0000_0005_0009_0003_0002_0001_0004;

    tbl[2].beats = '{default: 16'hABCD};
    tbl[2].nb = 10; tbl[2].lastf = 1'b0; tbl[2].err = 1'b1; tbl[2].exp_fc = 8'd1;
    tbl[2].exp_data = 160'h0006_0008_0007_0000_0005_0009_0003_0002_0001_0004;

    tbl[3].beats = '{default: 16'hFFFF};
    tbl[3].nb = 10; tbl[3].lastf = 1'b1; tbl[3].err = 1'b0; tbl[3].exp_fc = 8'd2;
    tbl[3].exp_data = {160{1'b1}};

    tbl[4].beats = '{16'h8000, 16'h7FFF, 16'h0001, 16'hFFFE, 16'h1234,
                     16'h8001, 16'h0000, 16'hFFFF, 16'h00FF, 16'hFF00};
    tbl[4].nb = 10; tbl[4].lastf = 1'b1; tbl[4].err = 1'b0; tbl[4].exp_fc = 8'd3;
    tbl[4].exp_data = 160'hFF00_00FF_FFFF_0000_8001_1234_FFFE_0001_7FFF_8000;

    for (int i = 0; i < 5; i++) begin
      send_frame(tbl[i].beats, tbl[i].nb, tbl[i].lastf, 2);
      chk("tbl_data_out", data_out, tbl[i].exp_data);
      chk("tbl_frame_cnt", frame_cnt, tbl[i].exp_fc);
      if (tbl[i].err) begin
        chk("tbl_err_len", err_len, 1'b1);
        chk("tbl_err_no_load", load, 1'b0);
        step();
        chk("tbl_err_len_once", err_len, 1'b0);
        chk("tbl_err_no_load2", load, 1'b0);
      end else begin
        chk("tbl_load_start", load, 1'b1);
        chk("tbl_no_err_len", err_len, 1'b0);
        release_frame(3);
      end
    end
    m_data = tbl[4].exp_data;
    m_fc   = 8'd3;

    // ---------------- overlap: next frame collected during WAIT ----------------
    for (int k = 0; k < 10; k++) fa[k] = 16'($urandom);
    for (int k = 0; k < 10; k++) fb[k] = 16'($urandom);
    send_frame(fa, 10, 1'b1, 0);
    m_fc++;
    m_data = pack(fa);
    chk("ovl_f1_load", load, 1'b1);
    chk("ovl_f1_data", data_out, m_data);
    for (int k = 0; k < 9; k++) send_beat(fb[k], 1'b0);
    in_valid = 1'b1;
    in_data  = fb[9];
    in_last  = 1'b1;
    chk("ovl_stall_ready", in_ready, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("ovl_stall_hold", in_ready, 1'b0);
      chk("ovl_stall_no_load", load, 1'b0);
    end
    chk("ovl_data_held", data_out, m_data);
    complete = 1'b1;
    step();
    complete = 1'b0;
    chk("ovl_ready_after_edge", in_ready, 1'b1);
    chk("ovl_no_load_yet", load, 1'b0);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    m_fc++;
    m_data = pack(fb);
    chk("ovl_f2_load", load, 1'b1);
    chk("ovl_f2_data", data_out, m_data);
    chk("ovl_f2_frame_cnt", frame_cnt, m_fc);
    release_frame(2);

    // ---------------- timeout; complete edge during LOAD is ignored ----------------
    for (int k = 0; k < 10; k++) fa[k] = 16'($urandom);
    for (int k = 0; k < 10; k++) fb[k] = 16'($urandom);
    send_frame(fa, 10, 1'b1, 1);
    m_fc++;
    m_data = pack(fa);
    chk("to_load", load, 1'b1);
    c0 = cyc;
    complete = 1'b1;
    for (int k = 0; k < 3; k++) send_beat(fb[k], 1'b0);
    n = 0;
    while (!err_timeout && n < 300) begin
      step();
      n++;
    end
    chk("to_seen", err_timeout, 1'b1);
    chk("to_latency", 160'(cyc - c0), 160'd66);
    chk("to_frame_cnt", frame_cnt, m_fc);
    chk("to_data_held", data_out, m_data);
    chk("to_ready_collect", in_ready, 1'b1);
    step();
    complete = 1'b0;
    chk("to_pulse_once", err_timeout, 1'b0);
    for (int k = 3; k < 10; k++) send_beat(fb[k], k == 9);
    m_fc++;
    m_data = pack(fb);
    chk("to_partial_kept_load", load, 1'b1);
    chk("to_partial_kept_data", data_out, m_data);
    chk("to_partial_frame_cnt", frame_cnt, m_fc);
    release_frame(2);

    // ---------------- reset in the middle of WAIT ----------------
    for (int k = 0; k < 10; k++) fa[k] = 16'($urandom);
    send_frame(fa, 10, 1'b1, 0);
    chk("rw_load", load, 1'b1);
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk("rw_ready_low_in_rst", in_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("rw_data_out", data_out, '0);
    chk("rw_load_low", load, 1'b0);
    chk("rw_frame_cnt", frame_cnt, 8'd0);
    rst = 1'b0;
    step();
    chk("rw_ready_collect", in_ready, 1'b1);
    m_data = '0;
    m_fc   = 8'd0;

    // ---------------- random frames vs frame-level model ----------------
    for (int f = 0; f < 450; f++) begin
      for (int k = 0; k < 10; k++) fa[k] = 16'($urandom);
      kind = int'($urandom_range(0, 9));
      if (kind <= 6) begin
        nb = 10; lastf = 1'b1;
      end else if (kind <= 8) begin
        nb = int'($urandom_range(1, 9)); lastf = 1'b1;
      end else begin
        nb = 10; lastf = 1'b0;
      end
      send_frame(fa, nb, lastf, 2);
      if (nb == 10 && lastf) begin
        m_fc++;
        m_data = pack(fa);
        chk("rnd_load", load, 1'b1);
        chk("rnd_data", data_out, m_data);
        chk("rnd_frame_cnt", frame_cnt, m_fc);
        release_frame(10);
      end else begin
        chk("rnd_err_len", err_len, 1'b1);
        chk("rnd_err_no_load", load, 1'b0);
        chk("rnd_err_data", data_out, m_data);
        chk("rnd_err_frame_cnt", frame_cnt, m_fc);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
